// File: rtl/mem_pkg.sv
// Shared sizing for the MEM-stage data memory.
// Default geometry and derived array dimensions.
package mem_pkg;

  localparam int DEF_B = 32;
  localparam int DEF_W = 10;

  localparam int BYTES_PER_WORD = DEF_B / 8;
  localparam int OFFSET_W = $clog2(BYTES_PER_WORD);
  localparam int DEPTH = 2 ** (DEF_W - OFFSET_W);

  // Byte-offset width for an arbitrary word width.
  function automatic int offset_w_of(input int b);
    return $clog2(b / 8);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with reset-clear, byte-lane writes
// and an asynchronous read port.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int AW = DEF_W - OFFSET_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [B/8-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [B-1:0]  wdata,
  output logic [B-1:0]  rdata
);

  localparam int N = 2 ** AW;
  localparam int LANES = B / 8;

  logic [B-1:0] mem [N];

  // Clear every word on reset, else merge enabled byte lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) begin
          mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: word-aligned store/load,
// registered load data and a combinational debug tap.
module data_memory
  import mem_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [W-1:0] i_addr,
  input  logic [B-1:0] i_data,
  output logic [B-1:0] o_data,
  output logic [B-1:0] o_debug_mem
);

  localparam int OFS = offset_w_of(B);
  localparam int AW = W - OFS;

  logic [AW-1:0] word;
  logic [B-1:0]  rdata;
  logic          unused_ofs;

  // Low address bits select a byte within the word and are dropped.
  assign word = i_addr[W-1:OFS];
  assign unused_ofs = ^i_addr[OFS-1:0];

  data_mem_array #(
    .B (B),
    .AW(AW)
  ) u_array (
    .clk  (i_clk),
    .reset(i_reset),
    .we   (i_mem_write),
    .be   ({(B/8){1'b1}}),
    .addr (word),
    .wdata(i_data),
    .rdata(rdata)
  );

  // Load register samples the pre-edge word, so a same-cycle
  // store is seen only by the following load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= '0;
    end else if (i_mem_read) begin
      o_data <= rdata;
    end
  end

  assign o_debug_mem = rdata;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: byte-level reference
// model compared every cycle, plus directed literal checks.
module tb_data_memory;

  localparam int B = 32;
  localparam int W = 10;
  localparam int NBYTES = 2 ** W;

  logic         clk;
  logic         reset;
  logic         rd;
  logic         wr;
  logic [W-1:0] addr;
  logic [B-1:0] din;
  logic [B-1:0] dout;
  logic [B-1:0] dbg;

  int pass_cnt;
  int total;
  bit started;

  logic [7:0]   ref_mem [NBYTES];
  logic [B-1:0] ref_data;

  data_memory #(
    .B(B),
    .W(W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_mem_read (rd),
    .i_mem_write(wr),
    .i_addr     (addr),
    .i_data     (din),
    .o_data     (dout),
    .o_debug_mem(dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [B-1:0] ref_word(input logic [W-1:0] a);
    int base;
    logic [B-1:0] v;
    base = int'(a) & ~3;
    v = {ref_mem[base+3], ref_mem[base+2],
         ref_mem[base+1], ref_mem[base]};
    return v;
  endfunction

  // Reference: whole-byte memory, load sees pre-edge contents.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
      ref_data = '0;
      started = 1'b1;
    end else begin
      if (rd) ref_data = ref_word(addr);
      if (wr) begin
        for (int k = 0; k < 4; k++)
          ref_mem[(int'(addr) & ~3) + k] = din[k*8 +: 8];
      end
    end
  end

  task automatic check(input string name,
                       input logic [B-1:0] act,
                       input logic [B-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model_o_data", dout, ref_data);
      check("model_debug", dbg, ref_word(addr));
    end
  end

  task automatic cycle(input logic r, input logic w,
                       input logic [W-1:0] a,
                       input logic [B-1:0] d);
    rd = r;
    wr = w;
    addr = a;
    din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [W-1:0] a, input logic [B-1:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic load(input logic [W-1:0] a);
    cycle(1'b1, 1'b0, a, '0);
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    started = 1'b0;
    reset = 1'b1;
    cycle(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    check("reset_o_data", dout, 32'h0);
    check("reset_debug", dbg, 32'h0);

    for (int i = 0; i < 10; i++) store(W'(4 * i), B'(i));
    for (int i = 0; i < 10; i++) begin
      load(W'(4 * i));
      check("sweep_o_data", dout, B'(i));
      check("sweep_debug", dbg, B'(i));
    end

    store(10'h008, 32'hDEADBEEF);
    load(10'h00B);
    check("align_o_data", dout, 32'hDEADBEEF);

    store(10'h010, 32'd5);
    cycle(1'b1, 1'b1, 10'h010, 32'd9);
    check("collide_old", dout, 32'd5);
    check("collide_dbg_new", dbg, 32'd9);
    load(10'h010);
    check("collide_next", dout, 32'd9);

    store(10'h01C, 32'd7);
    load(10'h01C);
    check("hold_load", dout, 32'd7);
    cycle(1'b0, 1'b0, 10'h000, '0);
    check("hold_o_data", dout, 32'd7);
    check("hold_debug", dbg, 32'd0);
    cycle(1'b0, 1'b0, 10'h004, '0);
    check("hold_debug_follow", dbg, 32'd1);
    check("hold_o_data2", dout, 32'd7);

    reset = 1'b1;
    cycle(1'b1, 1'b1, 10'h000, 32'hFF);
    reset = 1'b0;
    check("rst_o_data", dout, 32'h0);
    check("rst_debug0", dbg, 32'h0);
    load(10'h000);
    check("rst_load0", dout, 32'h0);
    for (int i = 0; i < NBYTES / 4; i++) load(W'(4 * i));
    load(10'h024);
    check("rst_load24", dout, 32'h0);

    store(10'h3FC, 32'h12345678);
    store(10'h000, 32'h000000AA);
    load(10'h3FC);
    check("bound_top", dout, 32'h12345678);
    load(10'h000);
    check("bound_zero", dout, 32'h000000AA);
    load(10'h3FF);
    check("bound_top_unaligned", dout, 32'h12345678);

    cycle(1'b0, 1'b0, '0, '0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
